// File: rtl/mips_uart_tx_if.sv
// Data-bus view of the UART TX register window.
// master = core side, slave = peripheral side.
interface mips_uart_tx_if;
    logic [31:0] adr;
    logic [31:0] writedata;
    logic        memwrite;
    logic [31:0] readdata;
    logic        sel;

    modport master (
        output adr, writedata, memwrite,
        input  readdata, sel
    );

    modport slave (
        input  adr, writedata, memwrite,
        output readdata, sel
    );
endinterface

// File: rtl/mips_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO.
// Optional even parity bit when UART_TX_PARITY_EN is defined.
module mips_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic           clk,
    input  logic           reset,
    mips_uart_tx_if.slave  bus,
    output logic           txd,
    output logic           busy
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] DEPTH    = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP
    } state_e;

    state_e          state_q, state_d;
    logic [BW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            txd_q, txd_d;
    logic [PW-1:0]   rd_q, wr_q;
    logic [CW-1:0]   count_q;
    logic            ovf_q, ovf_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [7:0]      head;
    logic            full, empty, pop, push, push_req, ovf_clr;
    logic [31:0]     status;
    logic            unused_bits;

    assign full  = (count_q == DEPTH);
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_q];

    assign bus.sel  = (bus.adr[31:3] == BASE_ADDR[31:3]);
    assign push_req = bus.sel & bus.memwrite & ~bus.adr[2];
    assign push     = push_req & ~full;
    assign ovf_clr  = bus.sel & bus.memwrite & bus.adr[2]
                    & bus.writedata[3];
    assign unused_bits = ^{bus.adr[1:0], bus.writedata[31:8]};

`ifdef UART_TX_PARITY_EN
    localparam logic   PAR_EN     = 1'b1;
    localparam state_e AFTER_DATA = PARITY;
    logic par_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) par_q <= 1'b0;
        else if (pop) par_q <= ^head;
    end
`else
    localparam logic   PAR_EN     = 1'b0;
    localparam state_e AFTER_DATA = STOP;
`endif

    always_comb begin
        pop     = 1'b0;
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        case (state_q)
            IDLE: if (!empty) begin
                pop     = 1'b1;
                state_d = START;
                cnt_d   = BAUD_MAX;
                shift_d = head;
            end
            START: if (cnt_q == '0) begin
                state_d = DATA;
                cnt_d   = BAUD_MAX;
                bit_d   = '0;
            end else cnt_d = cnt_q - BW'(1);
            DATA: if (cnt_q == '0) begin
                cnt_d = BAUD_MAX;
                if (bit_q == 3'd7) state_d = AFTER_DATA;
                else begin
                    bit_d   = bit_q + 3'd1;
                    shift_d = {1'b0, shift_q[7:1]};
                end
            end else cnt_d = cnt_q - BW'(1);
            PARITY: if (cnt_q == '0) begin
                state_d = STOP;
                cnt_d   = BAUD_MAX;
            end else cnt_d = cnt_q - BW'(1);
            STOP: if (cnt_q == '0) begin
                // Chain straight into the next frame: no idle gap.
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = START;
                    cnt_d   = BAUD_MAX;
                    shift_d = head;
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end else cnt_d = cnt_q - BW'(1);
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        txd_d = 1'b1;
        case (state_d)
            START:  txd_d = 1'b0;
            DATA:   txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY: txd_d = par_q;
`endif
            default: txd_d = 1'b1;
        endcase
    end

    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr) ovf_d = 1'b0;
        if (push_req & full) ovf_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
            ovf_q   <= ovf_d;
            if (push) wr_q <= wr_q + PW'(1);
            if (pop)  rd_q <= rd_q + PW'(1);
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= bus.writedata[7:0];
    end

    always_comb begin
        status        = '0;
        status[0]     = full;
        status[1]     = empty;
        status[2]     = (state_q != IDLE);
        status[3]     = ovf_q;
        status[4]     = PAR_EN;
        status[8 +: CW] = count_q;
    end

    assign bus.readdata = (bus.sel & bus.adr[2]) ? status : '0;
    assign txd  = txd_q;
    assign busy = (state_q != IDLE) | ~empty;
endmodule

// File: tb/tb_mips_uart_tx.sv
// Directed self-checking bench for mips_uart_tx.
// Define UART_TX_PARITY_EN here too to check the parity build.
module tb_mips_uart_tx;
    localparam logic [31:0] BASE = 32'hFFFF_0000;
    localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
    localparam logic PAR = 1'b1;
`else
    localparam logic PAR = 1'b0;
`endif
    localparam logic [31:0] STAT_IDLE = 32'h2 | (32'(PAR) << 4);

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic txd, busy;
    int errors = 0;
    int checks = 0;

    mips_uart_tx_if u_if();

    mips_uart_tx #(
        .BASE_ADDR(BASE),
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(u_if),
        .txd(txd),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic write_burst(input logic [7:0] d [6], input int n);
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            u_if.adr       = BASE;
            u_if.writedata = {24'h0, d[i]};
            u_if.memwrite  = 1'b1;
            @(posedge clk);
            #1;
        end
        u_if.memwrite = 1'b0;
        u_if.adr      = BASE + 32'd4;
    endtask

    // First sample lands just after the edge that starts the frame.
    task automatic expect_frame(input logic [7:0] b, input string nm);
        logic [10:0] bits;
        int nb;
        if (PAR) begin
            bits = {1'b1, ^b, b, 1'b0};
            nb = 11;
        end else begin
            bits = {2'b11, b, 1'b0};
            nb = 10;
        end
        for (int k = 0; k < nb * CPB; k++) begin
            @(negedge clk);
            checks++;
            if (txd !== bits[k / CPB]) begin
                errors++;
                $display("FAIL %s cyc%0d txd=%b exp=%b",
                         nm, k, txd, bits[k / CPB]);
            end
        end
    endtask

    task automatic test_reset;
        u_if.adr       = BASE + 32'd4;
        u_if.writedata = '0;
        u_if.memwrite  = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (u_if.readdata !== STAT_IDLE) begin
            errors++;
            $display("FAIL reset_status got=%h exp=%h",
                     u_if.readdata, STAT_IDLE);
        end
        checks++;
        if (u_if.sel !== 1'b1) begin
            errors++;
            $display("FAIL reset_sel got=%b exp=1", u_if.sel);
        end
        checks++;
        if (txd !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_line txd=%b busy=%b exp 1/0", txd, busy);
        end
    endtask

    task automatic test_single;
        logic [7:0] d [6];
        d = '{8'hA5, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0};
        fork
            write_burst(d, 1);
            begin
                @(negedge clk);
                @(posedge clk);
                @(negedge clk);
                checks++;
                if (txd !== 1'b1 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL single_pre txd=%b busy=%b exp 1/1",
                             txd, busy);
                end
                expect_frame(8'hA5, "single_A5");
                @(negedge clk);
                checks++;
                if (busy !== 1'b0 || txd !== 1'b1) begin
                    errors++;
                    $display("FAIL single_end busy=%b txd=%b exp 0/1",
                             busy, txd);
                end
            end
        join
    endtask

    task automatic test_back_to_back;
        logic [7:0] d [6];
        int lows;
        d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        fork
            write_burst(d, 6);
            begin
                @(negedge clk);
                @(posedge clk);
                @(negedge clk);
                for (int i = 0; i < 5; i++)
                    expect_frame(d[i], $sformatf("b2b_%0d", i));
                @(negedge clk);
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_busy got=%b exp=0", busy);
                end
            end
        join
        checks++;
        if (u_if.readdata !== (STAT_IDLE | 32'h8)) begin
            errors++;
            $display("FAIL b2b_overflow got=%h exp=%h",
                     u_if.readdata, STAT_IDLE | 32'h8);
        end
        lows = 0;
        repeat (40) begin
            @(negedge clk);
            if (txd !== 1'b1) lows++;
        end
        checks++;
        if (lows !== 0) begin
            errors++;
            $display("FAIL b2b_dropped lowcycles=%0d exp=0", lows);
        end
        @(negedge clk);
        u_if.adr       = BASE + 32'd4;
        u_if.writedata = 32'h8;
        u_if.memwrite  = 1'b1;
        @(posedge clk);
        #1 u_if.memwrite = 1'b0;
        @(negedge clk);
        checks++;
        if (u_if.readdata !== STAT_IDLE) begin
            errors++;
            $display("FAIL ovf_clear got=%h exp=%h",
                     u_if.readdata, STAT_IDLE);
        end
    endtask

    task automatic test_reset_midframe;
        logic [7:0] d [6];
        int lows;
        d = '{8'h3C, 8'hC3, 8'h5A, 8'h0, 8'h0, 8'h0};
        write_burst(d, 3);
        repeat (50) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (txd !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_line txd=%b busy=%b exp 1/0",
                     txd, busy);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (u_if.readdata !== STAT_IDLE) begin
            errors++;
            $display("FAIL midreset_status got=%h exp=%h",
                     u_if.readdata, STAT_IDLE);
        end
        lows = 0;
        repeat (300) begin
            @(negedge clk);
            if (txd !== 1'b1) lows++;
        end
        checks++;
        if (lows !== 0) begin
            errors++;
            $display("FAIL midreset_quiet lowcycles=%0d exp=0", lows);
        end
    endtask

    task automatic test_decode;
        int lows;
        @(negedge clk);
        u_if.adr       = BASE + 32'd8;
        u_if.writedata = 32'hFF;
        u_if.memwrite  = 1'b1;
        #1;
        checks++;
        if (u_if.sel !== 1'b0 || u_if.readdata !== 32'h0) begin
            errors++;
            $display("FAIL decode_base8 sel=%b rd=%h exp 0/0",
                     u_if.sel, u_if.readdata);
        end
        @(posedge clk);
        #1 u_if.adr = 32'h0;
        #1;
        checks++;
        if (u_if.sel !== 1'b0 || u_if.readdata !== 32'h0) begin
            errors++;
            $display("FAIL decode_zero sel=%b rd=%h exp 0/0",
                     u_if.sel, u_if.readdata);
        end
        @(posedge clk);
        #1 u_if.memwrite = 1'b0;
        u_if.adr = BASE + 32'd7;
        @(negedge clk);
        checks++;
        if (u_if.readdata !== STAT_IDLE || busy !== 1'b0) begin
            errors++;
            $display("FAIL decode_nopush rd=%h busy=%b exp %h/0",
                     u_if.readdata, busy, STAT_IDLE);
        end
        lows = 0;
        repeat (20) begin
            @(negedge clk);
            if (txd !== 1'b1) lows++;
        end
        checks++;
        if (lows !== 0) begin
            errors++;
            $display("FAIL decode_quiet lowcycles=%0d exp=0", lows);
        end
        u_if.adr = BASE + 32'd4;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_reset_midframe();
        test_decode();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule
